// File: rtl/pipe_regs.sv
// -----------------------------------------------------------------------------
// pipe_regs
//
// Pipeline register bank for a five-stage MIPS core. It holds the PC register,
// the IF/ID and ID/EX registers, and the destination-tracking registers for
// EX/MEM and MEM/WB. It also keeps saturating stall and flush counters for
// performance measurement.
//
// Parameters
//    RESET_PC    value loaded into pcF on reset
//    CNT_W       width of the stall and flush counters
//
// Ports
//    clk         rising-edge clock
//    reset       synchronous, active-high reset; overrides every other input
//    stallF      hold the PC register
//    stallD      hold the IF/ID register (takes priority over PCSrcD)
//    FlushE      load a bubble into ID/EX
//    PCSrcD      branch/jump taken in decode; clears IF/ID when not stalled
//    pcNextF     next PC
//    instrF      fetched instruction
//    pcF         current PC
//    instrD      decode-stage instruction
//    pcPlus4D    decode-stage PC+4
//    ctrlD       {RegWrite, MemToReg, MemWrite, ALUControl[2:0], ALUSrc, RegDst}
//    dataD       {srcA, srcB, signImm}
//    regsD       {rs, rt, rd}
//    ctrlE       registered ctrlD
//    dataE       registered dataD
//    rsE/rtE/rdE registered register specifiers
//    writeRegE   combinational: RegDstE ? rdE : rtE
//    writeRegM   destination register in MEM
//    writeRegW   destination register in WB
//    RegWriteM   RegWrite tracked into MEM
//    MemToRegM   MemToReg tracked into MEM
//    RegWriteW   RegWrite tracked into WB
//    stallCount  cycles with stallF asserted (saturating)
//    flushCount  flush events (saturating)
// -----------------------------------------------------------------------------
module pipe_regs #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stallF,
   input  logic             stallD,
   input  logic             FlushE,
   input  logic             PCSrcD,
   input  logic [31:0]      pcNextF,
   input  logic [31:0]      instrF,
   output logic [31:0]      pcF,
   output logic [31:0]      instrD,
   output logic [31:0]      pcPlus4D,
   input  logic [7:0]       ctrlD,
   input  logic [95:0]      dataD,
   input  logic [14:0]      regsD,
   output logic [7:0]       ctrlE,
   output logic [95:0]      dataE,
   output logic [4:0]       rsE,
   output logic [4:0]       rtE,
   output logic [4:0]       rdE,
   output logic [4:0]       writeRegE,
   output logic [4:0]       writeRegM,
   output logic [4:0]       writeRegW,
   output logic             RegWriteM,
   output logic             MemToRegM,
   output logic             RegWriteW,
   output logic [CNT_W-1:0] stallCount,
   output logic [CNT_W-1:0] flushCount
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Saturating increment: the counter sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      logic [CNT_W-1:0] result;
      if (value == CNT_MAX) begin
         result = CNT_MAX;
      end else begin
         result = value + CNT_ONE;
      end
      return result;
   endfunction

   logic        flush_if_s;     // IF/ID is actually cleared this cycle
   logic        flush_event_s;  // any flush activity this cycle (counted once)
   logic [31:0] pc_plus4_s;

   // Decode-stage flush and the combined flush event used by the counter.
   always_comb begin
      flush_if_s    = PCSrcD & ~stallD;
      flush_event_s = FlushE | flush_if_s;
      pc_plus4_s    = pcF + 32'd4;   // 32-bit wrap is intentional
   end

   // Destination register select in EX: RegDst is ctrlE[0].
   always_comb begin
      writeRegE = rtE;
      if (ctrlE[0]) begin
         writeRegE = rdE;
      end else begin
         writeRegE = rtE;
      end
   end

   // PC register.
   always_ff @(posedge clk) begin
      if (reset) begin
         pcF <= RESET_PC;
      end else if (!stallF) begin
         pcF <= pcNextF;
      end else begin
         pcF <= pcF;
      end
   end

   // IF/ID register: stall wins over a taken branch, so a stalled branch
   // keeps the decode instruction until the stall releases.
   always_ff @(posedge clk) begin
      if (reset) begin
         instrD   <= 32'd0;
         pcPlus4D <= 32'd0;
      end else if (stallD) begin
         instrD   <= instrD;
         pcPlus4D <= pcPlus4D;
      end else if (PCSrcD) begin
         instrD   <= 32'd0;
         pcPlus4D <= 32'd0;
      end else begin
         instrD   <= instrF;
         pcPlus4D <= pc_plus4_s;
      end
   end

   // ID/EX register: no stall here, a flush inserts an all-zero bubble.
   always_ff @(posedge clk) begin
      if (reset || FlushE) begin
         ctrlE <= 8'd0;
         dataE <= 96'd0;
         rsE   <= 5'd0;
         rtE   <= 5'd0;
         rdE   <= 5'd0;
      end else begin
         ctrlE <= ctrlD;
         dataE <= dataD;
         rsE   <= regsD[14:10];
         rtE   <= regsD[9:5];
         rdE   <= regsD[4:0];
      end
   end

   // EX/MEM destination tracking: ctrlE[7] is RegWrite, ctrlE[6] is MemToReg.
   always_ff @(posedge clk) begin
      if (reset) begin
         writeRegM <= 5'd0;
         RegWriteM <= 1'b0;
         MemToRegM <= 1'b0;
      end else begin
         writeRegM <= writeRegE;
         RegWriteM <= ctrlE[7];
         MemToRegM <= ctrlE[6];
      end
   end

   // MEM/WB destination tracking.
   always_ff @(posedge clk) begin
      if (reset) begin
         writeRegW <= 5'd0;
         RegWriteW <= 1'b0;
      end else begin
         writeRegW <= writeRegM;
         RegWriteW <= RegWriteM;
      end
   end

   // Stall counter: one count per cycle with stallF high.
   always_ff @(posedge clk) begin
      if (reset) begin
         stallCount <= '0;
      end else if (stallF) begin
         stallCount <= sat_inc(stallCount);
      end else begin
         stallCount <= stallCount;
      end
   end

   // Flush counter: a cycle with both an E flush and a D flush counts once.
   always_ff @(posedge clk) begin
      if (reset) begin
         flushCount <= '0;
      end else if (flush_event_s) begin
         flushCount <= sat_inc(flushCount);
      end else begin
         flushCount <= flushCount;
      end
   end

endmodule

// File: tb/tb_pipe_regs.sv
// -----------------------------------------------------------------------------
// tb_pipe_regs
//
// Self-checking bench for pipe_regs (RESET_PC = 32'h0040_0000). A behavioural
// model tracks per-stage contents; a table of directed vectors with
// hand-derived expectations, random traffic, reset-during-stall and counter
// saturation sequences are compared against it.
// -----------------------------------------------------------------------------
module tb_pipe_regs;

   localparam logic [31:0] RST_PC = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        reset, stallF, stallD, FlushE, PCSrcD;
   logic [31:0] pcNextF, instrF, pcF, instrD, pcPlus4D;
   logic [7:0]  ctrlD, ctrlE;
   logic [95:0] dataD, dataE;
   logic [14:0] regsD;
   logic [4:0]  rsE, rtE, rdE, writeRegE, writeRegM, writeRegW;
   logic        RegWriteM, MemToRegM, RegWriteW;
   logic [15:0] stallCount, flushCount;

   pipe_regs #(.RESET_PC(RST_PC), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .stallF(stallF), .stallD(stallD),
      .FlushE(FlushE), .PCSrcD(PCSrcD), .pcNextF(pcNextF), .instrF(instrF),
      .pcF(pcF), .instrD(instrD), .pcPlus4D(pcPlus4D), .ctrlD(ctrlD),
      .dataD(dataD), .regsD(regsD), .ctrlE(ctrlE), .dataE(dataE),
      .rsE(rsE), .rtE(rtE), .rdE(rdE), .writeRegE(writeRegE),
      .writeRegM(writeRegM), .writeRegW(writeRegW), .RegWriteM(RegWriteM),
      .MemToRegM(MemToRegM), .RegWriteW(RegWriteW),
      .stallCount(stallCount), .flushCount(flushCount)
   );

   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int check_cnt = 0;

   // Behavioural model: the contents of each pipeline stage.
   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc4;
   } d_stage_t;
   typedef struct {
      logic [7:0]  ctrl;
      logic [95:0] data;
      logic [4:0]  rs, rt, rd;
   } e_stage_t;
   typedef struct {
      logic [4:0] dst;
      logic       reg_write;
      logic       mem_to_reg;
   } mw_stage_t;

   logic [31:0] m_pc;
   d_stage_t    m_d;
   e_stage_t    m_e;
   mw_stage_t   m_m, m_w;
   int unsigned m_stalls, m_flushes;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      check_cnt++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         pass_cnt++;
      end
   endtask

   function automatic logic [4:0] m_dest(input e_stage_t e);
      return e.ctrl[0] ? e.rd : e.rt;
   endfunction

   task automatic compare_model();
      chk("pcF", pcF, m_pc);
      chk("instrD", instrD, m_d.instr);
      chk("pcPlus4D", pcPlus4D, m_d.pc4);
      chk("ctrlE", ctrlE, m_e.ctrl);
      chk("dataE", dataE, m_e.data);
      chk("rsE", rsE, m_e.rs);
      chk("rtE", rtE, m_e.rt);
      chk("rdE", rdE, m_e.rd);
      chk("writeRegE", writeRegE, m_dest(m_e));
      chk("writeRegM", writeRegM, m_m.dst);
      chk("RegWriteM", RegWriteM, m_m.reg_write);
      chk("MemToRegM", MemToRegM, m_m.mem_to_reg);
      chk("writeRegW", writeRegW, m_w.dst);
      chk("RegWriteW", RegWriteW, m_w.reg_write);
      chk("stallCount", stallCount, 128'(m_stalls));
      chk("flushCount", flushCount, 128'(m_flushes));
   endtask

   // Advance the model by one clock using the current inputs, clock the DUT,
   // then optionally compare everything.
   task automatic step(input bit do_check);
      d_stage_t  nd;
      e_stage_t  ne;
      mw_stage_t nm, nw;
      logic [31:0] npc;
      if (reset) begin
         npc = RST_PC;
         nd  = '{32'd0, 32'd0};
         ne  = '{8'd0, 96'd0, 5'd0, 5'd0, 5'd0};
         nm  = '{5'd0, 1'b0, 1'b0};
         nw  = '{5'd0, 1'b0, 1'b0};
         m_stalls  = 0;
         m_flushes = 0;
      end else begin
         npc = stallF ? m_pc : pcNextF;
         if (stallD)      nd = m_d;
         else if (PCSrcD) nd = '{32'd0, 32'd0};
         else             nd = '{instrF, m_pc + 32'd4};
         if (FlushE) ne = '{8'd0, 96'd0, 5'd0, 5'd0, 5'd0};
         else        ne = '{ctrlD, dataD, regsD[14:10], regsD[9:5], regsD[4:0]};
         nm = '{m_dest(m_e), m_e.ctrl[7], m_e.ctrl[6]};
         nw = m_m;
         if (stallF && m_stalls < 32'd65535) m_stalls++;
         if ((FlushE || (PCSrcD && !stallD)) && m_flushes < 32'd65535) m_flushes++;
      end
      m_pc = npc; m_d = nd; m_e = ne; m_m = nm; m_w = nw;
      @(posedge clk);
      #1;
      if (do_check) compare_model();
   endtask

   typedef struct {
      logic        sf, sd, fe, pcs;
      logic [31:0] pc_next, instr;
      logic [7:0]  ctrl;
      logic [14:0] regs;
      logic [31:0] e_pc, e_instr, e_pc4;
      logic [7:0]  e_ctrl;
      logic [4:0]  e_wre, e_wrm, e_wrw;
      logic [15:0] e_stall, e_flush;
   } vec_t;

   vec_t vecs[10];

   initial begin
      // Directed vectors applied right after reset; expectations are the
      // values seen just after the clock edge that consumes each row.
      vecs[0] = '{0,0,0,0, 32'h0040_0004, 32'h8C08_0004, 8'h00, 15'd0,
                  32'h0040_0004, 32'h8C08_0004, 32'h0040_0004, 8'h00, 5'd0, 5'd0, 5'd0, 16'd0, 16'd0};
      vecs[1] = '{0,0,0,0, 32'h0040_0008, 32'h0000_0020, 8'h81, {5'd1, 5'd8, 5'd9},
                  32'h0040_0008, 32'h0000_0020, 32'h0040_0008, 8'h81, 5'd9, 5'd0, 5'd0, 16'd0, 16'd0};
      vecs[2] = '{0,0,0,0, 32'h0040_000C, 32'h0000_0021, 8'h00, 15'd0,
                  32'h0040_000C, 32'h0000_0021, 32'h0040_000C, 8'h00, 5'd0, 5'd9, 5'd0, 16'd0, 16'd0};
      vecs[3] = '{0,0,0,0, 32'h0040_0010, 32'h0000_0022, 8'h00, 15'd0,
                  32'h0040_0010, 32'h0000_0022, 32'h0040_0010, 8'h00, 5'd0, 5'd0, 5'd9, 16'd0, 16'd0};
      vecs[4] = '{1,1,1,0, 32'h0040_0014, 32'h0000_0023, 8'hC1, {5'd2, 5'd3, 5'd4},
                  32'h0040_0010, 32'h0000_0022, 32'h0040_0010, 8'h00, 5'd0, 5'd0, 5'd0, 16'd1, 16'd1};
      vecs[5] = '{1,1,0,1, 32'h0040_0014, 32'h0000_0023, 8'h00, 15'd0,
                  32'h0040_0010, 32'h0000_0022, 32'h0040_0010, 8'h00, 5'd0, 5'd0, 5'd0, 16'd2, 16'd1};
      vecs[6] = '{0,0,0,1, 32'h0040_0100, 32'h0000_0024, 8'h00, 15'd0,
                  32'h0040_0100, 32'h0000_0000, 32'h0000_0000, 8'h00, 5'd0, 5'd0, 5'd0, 16'd2, 16'd2};
      vecs[7] = '{0,0,0,0, 32'hFFFF_FFFC, 32'h0000_0025, 8'h00, 15'd0,
                  32'hFFFF_FFFC, 32'h0000_0025, 32'h0040_0104, 8'h00, 5'd0, 5'd0, 5'd0, 16'd2, 16'd2};
      vecs[8] = '{0,0,0,0, 32'h0000_0000, 32'h0000_0026, 8'h00, 15'd0,
                  32'h0000_0000, 32'h0000_0026, 32'h0000_0000, 8'h00, 5'd0, 5'd0, 5'd0, 16'd2, 16'd2};
      vecs[9] = '{0,0,1,1, 32'h0000_0004, 32'h0000_0027, 8'h00, 15'd0,
                  32'h0000_0004, 32'h0000_0000, 32'h0000_0000, 8'h00, 5'd0, 5'd0, 5'd0, 16'd2, 16'd3};

      reset = 1'b1; stallF = 1'b0; stallD = 1'b0; FlushE = 1'b0; PCSrcD = 1'b0;
      pcNextF = 32'd0; instrF = 32'd0; ctrlD = 8'd0; dataD = 96'd0; regsD = 15'd0;

      // Reset state against fixed constants and against the model.
      step(1'b1);
      chk("rst_pcF", pcF, 32'h0040_0000);
      chk("rst_instrD", instrD, 32'd0);
      chk("rst_ctrlE", ctrlE, 8'd0);
      chk("rst_writeRegM", writeRegM, 5'd0);
      chk("rst_stallCount", stallCount, 16'd0);
      chk("rst_flushCount", flushCount, 16'd0);
      reset = 1'b0;

      // Directed table.
      for (int i = 0; i < 10; i++) begin
         stallF = vecs[i].sf; stallD = vecs[i].sd; FlushE = vecs[i].fe; PCSrcD = vecs[i].pcs;
         pcNextF = vecs[i].pc_next; instrF = vecs[i].instr;
         ctrlD = vecs[i].ctrl; regsD = vecs[i].regs;
         dataD = {3{32'hA5A5_0000 | 32'(i)}};
         step(1'b1);
         chk($sformatf("v%0d_pcF", i), pcF, vecs[i].e_pc);
         chk($sformatf("v%0d_instrD", i), instrD, vecs[i].e_instr);
         chk($sformatf("v%0d_pcPlus4D", i), pcPlus4D, vecs[i].e_pc4);
         chk($sformatf("v%0d_ctrlE", i), ctrlE, vecs[i].e_ctrl);
         chk($sformatf("v%0d_writeRegE", i), writeRegE, vecs[i].e_wre);
         chk($sformatf("v%0d_writeRegM", i), writeRegM, vecs[i].e_wrm);
         chk($sformatf("v%0d_writeRegW", i), writeRegW, vecs[i].e_wrw);
         chk($sformatf("v%0d_stallCount", i), stallCount, vecs[i].e_stall);
         chk($sformatf("v%0d_flushCount", i), flushCount, vecs[i].e_flush);
      end

      // Random traffic against the model, with occasional resets.
      for (int i = 0; i < 400; i++) begin
         reset   = ($urandom_range(0, 49) == 0);
         stallF  = ($urandom_range(0, 3) == 0);
         stallD  = ($urandom_range(0, 3) == 0);
         FlushE  = ($urandom_range(0, 3) == 0);
         PCSrcD  = ($urandom_range(0, 4) == 0);
         pcNextF = $urandom;
         instrF  = $urandom;
         ctrlD   = 8'($urandom);
         dataD   = {$urandom, $urandom, $urandom};
         regsD   = 15'($urandom);
         step(1'b1);
      end

      // Reset asserted in the middle of a load-use stall.
      reset = 1'b0; stallF = 1'b1; stallD = 1'b1; FlushE = 1'b1; PCSrcD = 1'b1;
      step(1'b1);
      reset = 1'b1;
      step(1'b1);
      chk("rst_mid_stall_pcF", pcF, 32'h0040_0000);
      chk("rst_mid_stall_stallCount", stallCount, 16'd0);
      chk("rst_mid_stall_flushCount", flushCount, 16'd0);

      // Stall counter saturation: reach 16'hFFFE, then three more stall cycles.
      reset = 1'b0; stallF = 1'b1; stallD = 1'b1; FlushE = 1'b0; PCSrcD = 1'b0;
      for (int i = 0; i < 65534; i++) step(1'b0);
      chk("sat_pre", stallCount, 16'hFFFE);
      compare_model();
      for (int i = 0; i < 3; i++) begin
         step(1'b1);
         chk($sformatf("sat_%0d", i), stallCount, 16'hFFFF);
      end

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
